// File: rtl/sgb_pkg.sv
// Shared types and constants for the SGB joypad port: packet FSM states,
// P14/P15 bit symbols and the MLT_REQ command code.
package sgb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_REL   = 3'd1,
        ST_BIT_WAIT  = 3'd2,
        ST_BIT_REL   = 3'd3,
        ST_STOP_WAIT = 3'd4,
        ST_STOP_REL  = 3'd5
    } rx_state_e;

    localparam logic [1:0] P54_RST  = 2'b00;
    localparam logic [1:0] P54_ZERO = 2'b10;
    localparam logic [1:0] P54_ONE  = 2'b01;
    localparam logic [1:0] P54_IDLE = 2'b11;

    localparam logic [4:0]  CMD_MLT_REQ = 5'h11;
    localparam int unsigned PKT_BITS    = 128;

    // MLT_REQ player-count code to (players - 1); code 10 is reserved and maps to one player
    function automatic logic [1:0] mlt_players(input logic [1:0] code);
        return (code == 2'b10) ? 2'b00 : code;
    endfunction

endpackage

// File: rtl/sgb_pkt_rx.sv
// SGB packet deserialiser: decodes P14/P15 symbols into bytes and raises
// one-clk write/done/error strobes after each clk_en sample.
module sgb_pkt_rx
    import sgb_pkg::*;
#(
    parameter int unsigned PKT_BYTES = PKT_BITS / 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_en_i,
    input  logic [1:0] joy_p54_i,
    output logic       pkt_wr_o,
    output logic [3:0] pkt_addr_o,
    output logic [7:0] pkt_data_o,
    output logic       pkt_done_o,
    output logic       pkt_err_o,
    output logic       done_c
);

    localparam int unsigned NBITS = PKT_BYTES * 8;
    localparam int unsigned CNT_W = $clog2(NBITS) + 1;

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               wr_q, wr_d;
    logic [3:0]         addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next state; strobes default low so each lasts exactly one clk
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        wr_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (clk_en_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (joy_p54_i == P54_RST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_RST_REL;
                    end
                end
                ST_RST_REL: begin
                    if (joy_p54_i == P54_IDLE) state_d = ST_BIT_WAIT;
                end
                ST_BIT_WAIT: begin
                    if (joy_p54_i == P54_RST) begin
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_RST_REL;
                    end else if (joy_p54_i != P54_IDLE) begin
                        shift_d   = {joy_p54_i == P54_ONE, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        state_d   = ST_BIT_REL;
                        if (bit_cnt_q[2:0] == 3'd7) begin
                            wr_d   = 1'b1;
                            addr_d = 4'(bit_cnt_q >> 3);
                            data_d = shift_d;
                        end
                    end
                end
                ST_BIT_REL: begin
                    if (joy_p54_i == P54_RST) begin
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_RST_REL;
                    end else if (joy_p54_i == P54_IDLE) begin
                        state_d = (bit_cnt_q == CNT_W'(NBITS)) ? ST_STOP_WAIT : ST_BIT_WAIT;
                    end
                end
                ST_STOP_WAIT: begin
                    if (joy_p54_i == P54_RST) begin
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_RST_REL;
                    end else if (joy_p54_i == P54_ZERO) begin
                        state_d = ST_STOP_REL;
                    end else if (joy_p54_i == P54_ONE) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_STOP_REL: begin
                    if (joy_p54_i == P54_IDLE) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign done_c     = done_d;
    assign pkt_wr_o   = wr_q;
    assign pkt_addr_o = addr_q;
    assign pkt_data_o = data_q;
    assign pkt_done_o = done_q;
    assign pkt_err_o  = err_q;

endmodule

// File: rtl/sgb_joypad_ctrl.sv
// SGB joypad port controller: multiplayer joy_din mux, player index tracking
// and MLT_REQ decode on top of the packet receiver.
module sgb_joypad_ctrl
    import sgb_pkg::*;
#(
    parameter int unsigned PKT_BYTES = PKT_BITS / 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_en,
    input  logic [1:0] joy_p54,
    output logic [3:0] joy_din,
    input  logic [7:0] joy0,
    input  logic [7:0] joy1,
    input  logic [7:0] joy2,
    input  logic [7:0] joy3,
    output logic       pkt_wr,
    output logic [3:0] pkt_addr,
    output logic [7:0] pkt_data,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [1:0] players,
    output logic [1:0] player_idx
);

    logic       done_c;
    logic [4:0] cmd_q;
    logic [1:0] mlt_code_q;
    logic [1:0] players_q, players_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] p54_prev_q;
    logic [3:0] joy_din_q, joy_din_d;
    logic [7:0] joy_sel;

    sgb_pkt_rx #(
        .PKT_BYTES (PKT_BYTES)
    ) u_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_en_i   (clk_en),
        .joy_p54_i  (joy_p54),
        .pkt_wr_o   (pkt_wr),
        .pkt_addr_o (pkt_addr),
        .pkt_data_o (pkt_data),
        .pkt_done_o (pkt_done),
        .pkt_err_o  (pkt_err),
        .done_c     (done_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q      <= '0;
            mlt_code_q <= '0;
            players_q  <= '0;
            idx_q      <= '0;
            p54_prev_q <= P54_IDLE;
            joy_din_q  <= 4'hF;
        end else begin
            if (pkt_wr && pkt_addr == 4'd0) cmd_q      <= pkt_data[7:3];
            if (pkt_wr && pkt_addr == 4'd1) mlt_code_q <= pkt_data[1:0];
            if (clk_en) p54_prev_q <= joy_p54;
            players_q <= players_d;
            idx_q     <= idx_d;
            joy_din_q <= joy_din_d;
        end
    end

    // MLT_REQ completion takes priority over an index step on the same sample
    always_comb begin
        players_d = players_q;
        idx_d     = idx_q;
        if (clk_en) begin
            if (done_c && cmd_q == CMD_MLT_REQ) begin
                players_d = mlt_players(mlt_code_q);
                idx_d     = 2'd0;
            end else if (players_q == 2'd0) begin
                idx_d = 2'd0;
            end else if (!p54_prev_q[0] && joy_p54 == P54_IDLE) begin
                idx_d = (idx_q == players_q) ? 2'd0 : idx_q + 2'd1;
            end
        end
    end

    always_comb begin
        joy_sel = joy0;
        unique case (idx_q)
            2'd1:    joy_sel = joy1;
            2'd2:    joy_sel = joy2;
            2'd3:    joy_sel = joy3;
            default: joy_sel = joy0;
        endcase
    end

    always_comb begin
        joy_din_d = 4'hF;
        unique case (joy_p54)
            P54_ZERO: joy_din_d = ~joy_sel[3:0];
            P54_ONE:  joy_din_d = ~joy_sel[7:4];
            P54_RST:  joy_din_d = ~(joy_sel[3:0] | joy_sel[7:4]);
            default:  joy_din_d = ~{2'b00, idx_q};
        endcase
    end

    assign joy_din    = joy_din_q;
    assign players    = players_q;
    assign player_idx = idx_q;

endmodule

// File: tb/tb_sgb_joypad_ctrl.sv
// Bench for sgb_joypad_ctrl: symbol-level stimulus announces the strobe each
// sample must produce; a per-cycle model predicts every output.
module tb_sgb_joypad_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clk_en = 1'b0;
    logic [1:0] joy_p54 = 2'b11;
    logic [7:0] joy0 = 8'h00, joy1 = 8'h00, joy2 = 8'h00, joy3 = 8'h00;
    logic [3:0] joy_din;
    logic       pkt_wr, pkt_done, pkt_err;
    logic [3:0] pkt_addr;
    logic [7:0] pkt_data;
    logic [1:0] players, player_idx;

    int checks = 0;
    int errors = 0;
    int n_wr = 0, n_done = 0, n_err = 0;

    logic [7:0] pb [16];

    // Announcements for the next clk_en sample, written only by the stimulus
    logic       nx_wr = 0, nx_done = 0, nx_err = 0, nx_mlt = 0;
    logic [3:0] nx_addr = 0;
    logic [7:0] nx_data = 0;
    logic [1:0] nx_pl = 0;

    logic [3:0] e_joy = 4'hF;
    logic       e_wr = 0, e_done = 0, e_err = 0;
    logic [3:0] e_addr = 0;
    logic [7:0] e_data = 0;
    logic [1:0] e_players = 0, e_idx = 0, m_prev = 2'b11;

    sgb_joypad_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_en     (clk_en),
        .joy_p54    (joy_p54),
        .joy_din    (joy_din),
        .joy0       (joy0),
        .joy1       (joy1),
        .joy2       (joy2),
        .joy3       (joy3),
        .pkt_wr     (pkt_wr),
        .pkt_addr   (pkt_addr),
        .pkt_data   (pkt_data),
        .pkt_done   (pkt_done),
        .pkt_err    (pkt_err),
        .players    (players),
        .player_idx (player_idx)
    );

    always #5 clk = ~clk;

    int unsigned en_cnt = 0;
    always @(negedge clk) begin
        en_cnt = en_cnt + 1;
        clk_en = (en_cnt % 3) != 0;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model
    always @(posedge clk or negedge reset_n) begin
        logic [7:0] sel;
        if (!reset_n) begin
            e_joy = 4'hF; e_wr = 0; e_done = 0; e_err = 0;
            e_addr = 0; e_data = 0; e_players = 0; e_idx = 0; m_prev = 2'b11;
        end else begin
            case (e_idx)
                2'd0: sel = joy0;
                2'd1: sel = joy1;
                2'd2: sel = joy2;
                default: sel = joy3;
            endcase
            case (joy_p54)
                2'b10:   e_joy = ~sel[3:0];
                2'b01:   e_joy = ~sel[7:4];
                2'b00:   e_joy = ~(sel[3:0] | sel[7:4]);
                default: e_joy = 4'(15 - int'(e_idx));
            endcase
            e_wr = 0; e_done = 0; e_err = 0;
            if (clk_en) begin
                e_wr = nx_wr; e_done = nx_done; e_err = nx_err;
                if (nx_wr) begin e_addr = nx_addr; e_data = nx_data; end
                if (nx_mlt) begin
                    e_players = nx_pl;
                    e_idx = 2'd0;
                end else if (m_prev[0] == 1'b0 && joy_p54 == 2'b11 && e_players != 0) begin
                    e_idx = 2'((int'(e_idx) + 1) % (int'(e_players) + 1));
                end
                m_prev = joy_p54;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        chk("joy_din", int'(joy_din), int'(e_joy));
        chk("pkt_wr", int'(pkt_wr), int'(e_wr));
        chk("pkt_done", int'(pkt_done), int'(e_done));
        chk("pkt_err", int'(pkt_err), int'(e_err));
        chk("pkt_addr", int'(pkt_addr), int'(e_addr));
        chk("pkt_data", int'(pkt_data), int'(e_data));
        chk("players", int'(players), int'(e_players));
        chk("player_idx", int'(player_idx), int'(e_idx));
        if (pkt_wr) n_wr = n_wr + 1;
        if (pkt_done) n_done = n_done + 1;
        if (pkt_err) n_err = n_err + 1;
    end

    task automatic wait_sample();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!clk_en && n < 8);
        if (!clk_en) begin
            errors = errors + 1;
            $display("FAIL sample_timeout at %0t: got no clk_en, expected one within 8 clk", $time);
        end
    endtask

    // Drive one symbol for two samples; the strobe fields describe the first sample
    task automatic sym(input logic [1:0] v, input bit wr, input logic [3:0] a,
                       input logic [7:0] d, input bit dn, input bit er,
                       input bit mlt, input logic [1:0] pl);
        @(negedge clk);
        joy_p54 = v;
        nx_wr = wr; nx_addr = a; nx_data = d; nx_done = dn; nx_err = er; nx_mlt = mlt; nx_pl = pl;
        wait_sample();
        @(negedge clk);
        nx_wr = 0; nx_done = 0; nx_err = 0; nx_mlt = 0;
        wait_sample();
    endtask

    task automatic idle_sym(input logic [1:0] v);
        sym(v, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic send_pkt(input int nbits, input bit stop1, input bit start_err);
        logic [1:0] pl;
        sym(2'b00, 1'b0, 4'd0, 8'd0, 1'b0, start_err, 1'b0, 2'd0);
        idle_sym(2'b11);
        for (int i = 0; i < nbits; i++) begin
            logic [7:0] byt;
            byt = pb[i / 8];
            sym(byt[i % 8] ? 2'b01 : 2'b10, (i % 8) == 7, 4'(i / 8), byt, 1'b0, 1'b0, 1'b0, 2'd0);
            idle_sym(2'b11);
        end
        if (nbits == 128) begin
            pl = (pb[1][1:0] == 2'b10) ? 2'b00 : pb[1][1:0];
            if (!stop1) begin
                idle_sym(2'b10);
                sym(2'b11, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, pb[0][7:3] == 5'h11, pl);
            end else begin
                sym(2'b01, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 2'd0);
                idle_sym(2'b11);
            end
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic clr_counts();
        @(negedge clk);
        #2;
        n_wr = 0; n_done = 0; n_err = 0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, expected finish before 600000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        #2;
        chk("rst_joy_din", int'(joy_din), 4'hF);
        chk("rst_strobes", int'({pkt_wr, pkt_done, pkt_err}), 0);
        chk("rst_players", int'(players), 0);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Direction read of player 1
        @(negedge clk);
        joy0 = 8'h01; joy_p54 = 2'b10;
        @(negedge clk);
        #2 chk("dir_read", int'(joy_din), 4'hE);
        idle_sym(2'b11);

        // MLT_REQ for two players
        joy0 = 8'h3C; joy1 = 8'hA5; joy2 = 8'h0F; joy3 = 8'hF0;
        foreach (pb[i]) pb[i] = 8'h00;
        pb[0] = 8'h89; pb[1] = 8'h01;
        clr_counts();
        send_pkt(128, 1'b0, 1'b0);
        settle();
        chk("mlt_wr_count", n_wr, 16);
        chk("mlt_done_count", n_done, 1);
        chk("mlt_players", int'(players), 1);
        chk("mlt_idx", int'(player_idx), 0);

        // Index stepping with two players
        joy1 = 8'h10;
        idle_sym(2'b10);
        idle_sym(2'b11);
        settle();
        chk("idx_step1", int'(joy_din), 4'hE);
        idle_sym(2'b01);
        settle();
        chk("p2_buttons", int'(joy_din), 4'hE);
        idle_sym(2'b11);
        idle_sym(2'b10);
        idle_sym(2'b11);
        settle();
        chk("idx_step2", int'(joy_din), 4'hF);

        // Abort after 37 bits, then a four-player MLT_REQ
        joy1 = 8'hA5;
        for (int i = 0; i < 16; i++) pb[i] = 8'($urandom);
        pb[0] = 8'h89; pb[1] = 8'h03;
        clr_counts();
        send_pkt(37, 1'b0, 1'b0);
        send_pkt(128, 1'b0, 1'b1);
        settle();
        chk("abort_err_count", n_err, 1);
        chk("abort_wr_count", n_wr, 20);
        chk("abort_done_count", n_done, 1);
        chk("four_players", int'(players), 3);

        // Stop bit of 1 rejects the packet
        pb[1] = 8'h00;
        clr_counts();
        send_pkt(128, 1'b1, 1'b0);
        settle();
        chk("stop1_err_count", n_err, 1);
        chk("stop1_done_count", n_done, 0);
        chk("stop1_players", int'(players), 3);

        // Reset during byte 7, then a clean non-MLT packet
        for (int i = 0; i < 16; i++) pb[i] = 8'($urandom);
        pb[0] = 8'h42;
        send_pkt(60, 1'b0, 1'b0);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #2;
        chk("mid_rst_joy_din", int'(joy_din), 4'hF);
        chk("mid_rst_strobes", int'({pkt_wr, pkt_done, pkt_err}), 0);
        chk("mid_rst_addr", int'(pkt_addr), 0);
        chk("mid_rst_data", int'(pkt_data), 0);
        chk("mid_rst_players", int'(players), 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        clr_counts();
        send_pkt(128, 1'b0, 1'b0);
        settle();
        chk("post_rst_wr_count", n_wr, 16);
        chk("post_rst_done_count", n_done, 1);
        chk("post_rst_last_addr", int'(pkt_addr), 15);
        chk("post_rst_last_data", int'(pkt_data), int'(pb[15]));
        chk("post_rst_players", int'(players), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
